// File: rtl/multdiv_ctrl_if.sv
// Handshake between the E-stage issue logic and the multiply/divide sequencer.
// The master side issues operations; the slave side (the controller) returns status and HI/LO.
interface multdiv_ctrl_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, md_use_D,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, md_use_D,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Multiply/divide sequencer: holds HI/LO, models fixed latency with a countdown, requests stalls.
// Define MULTDIV_MADD_EN to add MADD/MADDU (ops 7/8) accumulating into {HI,LO}.
module multdiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  multdiv_ctrl_if.slave md
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MULTDIV_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
`endif
  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      r_state;
  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_rs;
  logic [31:0] r_rt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_long;
  logic        w_div_start;
  logic        w_signed_div;
  logic [31:0] w_num;
  logic [31:0] w_den;
  logic [31:0] w_den_safe;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_res;

  always_comb begin
    w_long = (md.op >= OpMult) && (md.op <= OpDivu);
`ifdef MULTDIV_MADD_EN
    w_long = w_long || (md.op == OpMadd) || (md.op == OpMaddu);
`endif
  end

  assign w_div_start = (md.op == OpDiv) || (md.op == OpDivu);

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign w_prod_s = {{32{r_rs[31]}}, r_rs} * {{32{r_rt[31]}}, r_rt};
  assign w_prod_u = {32'b0, r_rs} * {32'b0, r_rt};

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with remainder 0.
  assign w_signed_div = (r_op == OpDiv);
  assign w_num        = (w_signed_div && r_rs[31]) ? -r_rs : r_rs;
  assign w_den        = (w_signed_div && r_rt[31]) ? -r_rt : r_rt;
  assign w_den_safe   = (r_rt == '0) ? 32'd1 : w_den;
  assign w_uq         = w_num / w_den_safe;
  assign w_ur         = w_num % w_den_safe;
  assign w_sq         = (r_rs[31] ^ r_rt[31]) ? -w_uq : w_uq;
  assign w_sr         = r_rs[31] ? -w_ur : w_ur;

  always_comb begin
    w_res = {r_hi, r_lo};
    case (r_op)
      OpMult:  w_res = w_prod_s;
      OpMultu: w_res = w_prod_u;
      OpDiv:   if (r_rt != '0) w_res = {w_sr, w_sq};
      OpDivu:  if (r_rt != '0) w_res = {w_ur, w_uq};
`ifdef MULTDIV_MADD_EN
      OpMadd:  w_res = {r_hi, r_lo} + w_prod_s;
      OpMaddu: w_res = {r_hi, r_lo} + w_prod_u;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (md.start) begin
            if (w_long) begin
              r_op    <= md.op;
              r_rs    <= md.rs_val;
              r_rt    <= md.rt_val;
              r_cnt   <= w_div_start ? DivLoad : MultLoad;
              r_busy  <= 1'b1;
              r_state <= StRun;
            end else if (md.op == OpMthi) begin
              r_hi <= md.rs_val;
            end else if (md.op == OpMtlo) begin
              r_lo <= md.rs_val;
            end
          end
        end
        StRun: begin
          // Issue attempts while running are dropped; the hazard unit should prevent them.
          if (r_cnt == 4'd1) begin
            r_hi    <= w_res[63:32];
            r_lo    <= w_res[31:0];
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign md.busy      = r_busy;
  assign md.hi        = r_hi;
  assign md.lo        = r_lo;
  assign md.stall_req = (r_busy | (md.start & w_long)) & md.md_use_D;

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencing controller for the multiply/divide resource in the E stage of the 5-stage pipeline. It accepts one operation per issue, holds HI/LO, models the fixed multi-cycle latency with a countdown, and raises a stall request toward the hazard unit. A D-stage instruction that needs HI/LO or the unit waits until the unit is free. Results leave through hi/lo, which feed the multdiv result path of the E/M and M/W pipeline registers.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..15
DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  E-stage instruction is a valid multdiv op this cycle
op  input  4  operation code (see Behaviour)
rs_val  input  32  forwarded rs operand
rt_val  input  32  forwarded rt operand
md_use_D  input  1  D-stage instruction is any multdiv-class instruction (mult/div/mf/mt)
busy  output  1  unit is computing
stall_req  output  1  request to freeze F/D and bubble E
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: synchronous, active-high, clock clk. Sets busy=0, hi=0, lo=0, counter=0, latched operands=0 and state IDLE. Reset during RUN aborts the operation and no result is committed.
- op encoding:
  - 0 NOP
  - 1 MULT: signed 32x32 to 64
  - 2 MULTU: unsigned
  - 3 DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend
  - 4 DIVU: unsigned
  - 5 MTHI: hi<=rs_val
  - 6 MTLO: lo<=rs_val
  - 7-8 reserved (see Optional Feature)
  - 9-15 illegal, treated as NOP
- States: IDLE and RUN.
- IDLE, start=1, op in 1-4:
  - Latch op, rs_val and rt_val.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN. busy=1 from the next cycle.
- IDLE, start=1, op 5/6: write hi/lo on that edge. No busy, stay in IDLE.
- RUN: counter decrements each cycle. In the cycle counter==1:
  - Commit the result to hi/lo on that edge.
  - busy=0 and IDLE from the next cycle.
  - busy is therefore high for exactly N cycles.
- start while in RUN is ignored (no latch, no hi/lo write). The hazard unit guarantees this never occurs in legal operation.
- Division by zero (rt latched ==0) for op 3/4: runs the full DIV_CYCLES and leaves hi/lo unchanged.
- DIV 0x80000000 / -1: lo=0x80000000, hi=0 (wrap, no trap).
- stall_req is combinational: (busy | (start & op in 1-4)) & md_use_D.
- hi/lo change only on commit, mthi/mtlo or reset. Their values are stable while busy.

Optional Feature:
- Macro: MULTDIV_MADD_EN.
- Defined:
  - op 7 MADD: {hi,lo} <= {hi,lo} + signed(rs*rt).
  - op 8 MADDU: the same with an unsigned product.
  - Both use MULT_CYCLES. The accumulation uses the hi/lo value at the commit edge, mod 2^64.
- Undefined: op 7/8 are treated as NOP, and the accumulator logic is absent.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles; at commit hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU rs=100, rt=7 with md_use_D=1 during the run -> stall_req high on the start cycle and for all 10 busy cycles; at commit lo=14, hi=2.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV by rt=0 -> busy 10 cycles, hi/lo unchanged.
- MTHI rs=0x12345678 while IDLE -> hi=0x12345678 next cycle, busy stays 0. MTLO issued while in RUN -> lo unchanged.
- MULT 3x4, reset asserted on the 3rd busy cycle -> busy=0, hi=lo=0 next cycle, and no commit afterwards.
- With MULTDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 -> hi=1, lo=0 after 5 cycles. Without the macro, op 7 -> hi/lo unchanged, busy stays 0.
